// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction-fetch stage: next-PC select
// encodings, the default bubble instruction and the fetch FSM state type.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Next-PC select from the decoder; 2'b11 behaves as PC+4.
    localparam logic [1:0] PCSRC_JALR   = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_PLUS4  = 2'b10;

    // addi x0,x0,0 : shown to the decoder whenever nothing valid is held.
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection with alignment check.
module next_pc_gen
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            target_misaligned
);

    logic [XLEN-1:0] w_jalr_target;

    // JALR clears bit 0 of rs1+imm; bit 1 may still be set and is caught below.
    assign w_jalr_target = alu_result & ~XLEN'(1);

    // Select the next PC; all adds wrap modulo 2^32.
    always_comb begin
        next_pc = pc + XLEN'(4);
        case (pcsrc)
            PCSRC_JALR:   next_pc = w_jalr_target;
            PCSRC_TARGET: next_pc = pc + imm_ext;
            default:      next_pc = pc + XLEN'(4);
        endcase
    end

    assign target_misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction over
// a req/ready handshake, presents it until commit, then advances the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic [31:0] instret
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_plus4;
    logic [XLEN-1:0] r_instr;
    logic            r_valid;
    logic            r_req;
    logic            r_misalign;
    logic [XLEN-1:0] r_instret;

    logic [XLEN-1:0] w_next_pc;
    logic            w_target_misaligned;

    next_pc_gen u_next_pc_gen (
        .pc                (r_pc),
        .pcsrc             (pcsrc),
        .imm_ext           (imm_ext),
        .alu_result        (alu_result),
        .next_pc           (w_next_pc),
        .target_misaligned (w_target_misaligned)
    );

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + XLEN'(4);
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_misalign <= 1'b0;
            r_instret  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (commit) begin
                        r_instret <= r_instret + XLEN'(1);
                        r_valid   <= 1'b0;
                        r_instr   <= NOP_INSTR;
                        if (w_target_misaligned) begin
                            // PC stays at the faulting instruction for debug.
                            r_misalign <= 1'b1;
                            r_state    <= ST_HALT;
                        end else begin
                            r_pc       <= w_next_pc;
                            r_pc_plus4 <= w_next_pc + XLEN'(4);
                            r_req      <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc_plus4;
    assign misalign    = r_misalign;
    assign instret     = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of fetch/commit vectors plus
// hand-written sequences for halt, wait states and asynchronous reset.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] instret;

    int n_vec;
    int n_err;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pcsrc       (pcsrc),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pcsrc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) until a fetch request is visible.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL wait_req: timeout, imem_req=%b expected 1", imem_req);
        end
    endtask

    // Serve one fetch after 'waits' stall cycles; noise on rdata/commit while stalled.
    task automatic do_fetch(input logic [31:0] exp_addr, input int waits, input logic [31:0] data);
        wait_req();
        chk("fetch_addr", imem_addr, exp_addr);
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            commit     = w[0];
            @(negedge clk);
            chk("stall_addr", imem_addr, exp_addr);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_valid", 32'(instr_valid), 32'd0);
            chk("stall_instr", instruction, NOP);
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        commit     = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("exec_instr", instruction, data);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_req", 32'(imem_req), 32'd0);
    endtask

    // Hold EXEC for 'idle' cycles with garbage select inputs, then commit.
    task automatic do_commit(input logic [1:0] sel, input logic [31:0] imm,
                             input logic [31:0] alu, input int idle, input logic [31:0] held);
        for (int k = 0; k < idle; k++) begin
            commit     = 1'b0;
            pcsrc      = 2'($urandom);
            imm_ext    = $urandom;
            alu_result = $urandom;
            @(negedge clk);
            chk("hold_instr", instruction, held);
            chk("hold_valid", 32'(instr_valid), 32'd1);
        end
        commit     = 1'b1;
        pcsrc      = sel;
        imm_ext    = imm;
        alu_result = alu;
        @(negedge clk);
        commit     = 1'b0;
        pcsrc      = 2'($urandom);
        imm_ext    = $urandom;
        alu_result = $urandom;
    endtask

    initial begin
        logic [31:0] cur_pc;
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{2'b00, 32'h0,         32'h0000_0FFD, 32'h0050_0093, 32'h0000_0FFC};
        vecs[1] = '{2'b10, 32'h0,         32'h0,         32'h0000_0113, 32'h0000_1000};
        vecs[2] = '{2'b11, 32'h1234_5678, 32'h0,         32'h0020_8193, 32'h0000_1004};
        vecs[3] = '{2'b00, 32'h0,         32'h0000_0020, 32'h0000_0067, 32'h0000_0020};
        vecs[4] = '{2'b01, 32'hFFFF_FFF8, 32'h0,         32'hFE00_0CE3, 32'h0000_0018};
        vecs[5] = '{2'b00, 32'h0,         32'h0000_0045, 32'h0040_80E7, 32'h0000_0044};
        vecs[6] = '{2'b00, 32'h0,         32'hFFFF_FFFD, 32'h0000_0067, 32'hFFFF_FFFC};
        vecs[7] = '{2'b10, 32'h0,         32'h0,         32'h0010_0073, 32'h0000_0000};
        vecs[8] = '{2'b01, 32'h0000_0010, 32'h0,         32'h0100_006F, 32'h0000_0010};

        rst        = 1'b1;
        pcsrc      = 2'b10;
        imm_ext    = '0;
        alu_result = '0;
        commit     = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_instr", instruction, NOP);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_instret", instret, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("req_after_idle", 32'(imem_req), 32'd1);
        chk("addr_after_idle", imem_addr, 32'h0);

        // Table: fetch at the current PC, commit, then check the redirected fetch.
        cur_pc = 32'h0;
        for (int i = 0; i < 9; i++) begin
            do_fetch(cur_pc, 0, vecs[i].rdata);
            chk("exec_pc_plus4", pc_plus4, cur_pc + 32'd4);
            do_commit(vecs[i].pcsrc, vecs[i].imm, vecs[i].alu, i % 3, vecs[i].rdata);
            chk("next_pc", pc, vecs[i].exp_pc);
            chk("next_addr", imem_addr, vecs[i].exp_pc);
            chk("next_pc_plus4", pc_plus4, vecs[i].exp_pc + 32'd4);
            chk("next_req", 32'(imem_req), 32'd1);
            chk("next_valid", 32'(instr_valid), 32'd0);
            chk("next_instr", instruction, NOP);
            chk("next_instret", instret, 32'(i + 1));
            chk("next_misalign", 32'(misalign), 32'd0);
            cur_pc = vecs[i].exp_pc;
        end

        // Misaligned branch target at pc=0x10 halts fetch.
        do_fetch(32'h10, 0, 32'h0000_0163);
        do_commit(2'b01, 32'h2, 32'h0, 0, 32'h0000_0163);
        chk("halt_misalign", 32'(misalign), 32'd1);
        chk("halt_pc", pc, 32'h10);
        chk("halt_instret", instret, 32'd10);
        for (int c = 0; c < 10; c++) begin
            imem_ready = 1'b1;
            commit     = 1'b1;
            pcsrc      = 2'b10;
            @(negedge clk);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            chk("halt_pc_hold", pc, 32'h10);
            chk("halt_sticky", 32'(misalign), 32'd1);
        end
        imem_ready = 1'b0;
        commit     = 1'b0;

        // Reset leaves HALT asynchronously.
        #2 rst = 1'b1;
        #1;
        chk("halt_rst_misalign", 32'(misalign), 32'd0);
        chk("halt_rst_instret", instret, 32'd0);
        chk("halt_rst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Wait states with toggling data and stray commits.
        do_fetch(32'h0, 3, 32'h00A0_0113);
        chk("ws_instret", instret, 32'd0);
        do_commit(2'b10, 32'h0, 32'h0, 1, 32'h00A0_0113);
        chk("ws_next_pc", pc, 32'h4);
        chk("ws_instret_after", instret, 32'd1);

        // Reset mid-FETCH drops the request asynchronously and restarts at RESET_PC.
        wait_req();
        imem_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instret", instret, 32'd0);
        chk("mid_rst_instr", instruction, NOP);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 0, 32'h0050_0093);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V core, directly upstream of the instruction decoder/controller. Holds the program counter and issues word fetches to instruction memory over a req/ready handshake. Presents the captured 32-bit instruction until the core signals commit, then computes the next PC from the decoder's `pcsrc`, immediate and ALU result. A misaligned target halts fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): instruction output value whenever no valid instruction is held.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pcsrc` in 2: next-PC select from decoder. 00 = JALR target, 01 = PC+imm (JAL or taken branch), 10 = PC+4, 11 = PC+4.
- `imm_ext` in 32: sign-extended immediate from immediate generator.
- `alu_result` in 32: ALU output, the JALR target rs1+imm.
- `commit` in 1: core has finished executing the held instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address (= `pc`).
- `imem_ready` in 1: memory returns data this cycle.
- `imem_rdata` in 32: instruction word, sampled only when `imem_req & imem_ready`.
- `instruction` out 32: held instruction to decoder.
- `instr_valid` out 1: `instruction` is valid for execution.
- `pc` out 32: address of held/current fetch.
- `pc_plus4` out 32: `pc`+4, consumed as the JAL/JALR link value.
- `misalign` out 1: sticky; fetch halted on misaligned target.
- `instret` out 32: count of committed instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset. Goes to FETCH on the next clock unconditionally.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, held stable until ready.
  - On `imem_ready`: capture `imem_rdata`, go to EXEC.
- EXEC:
  - `instr_valid`=1 and `instruction` is stable.
  - On `commit`: `instret` increments and `next_pc` is computed.
  - If `next_pc[1:0]`≠0: go to HALT, set `misalign`, leave `pc` unchanged.
  - Otherwise `pc`←`next_pc`, `instruction`←`NOP_INSTR`, go to FETCH.
- HALT: `imem_req`=0 and `instr_valid`=0. Exits only on `rst`.
- `next_pc` by `pcsrc`:
  - 00: `{alu_result[31:1],1'b0}` (LSB cleared per JALR).
  - 01: `pc`+`imm_ext`.
  - 10/11: `pc`+4.
- All adds are 32-bit modulo 2^32; wrap-around is silent. `pc_plus4` wraps the same way.
- `commit` outside EXEC is ignored. `imem_ready` outside FETCH is ignored.
- `instret` wraps from 32'hFFFF_FFFF to 0. It counts the commit that causes HALT.

## Timing
- Reset values:
  - state IDLE, `pc`=`RESET_PC`, `instruction`=`NOP_INSTR`.
  - `instr_valid`=0, `imem_req`=0, `misalign`=0, `instret`=0.
- Outputs are decoded from registered state only. There is no combinational path from `imem_ready` or `commit` to any output.
- Zero-wait memory: ready in the same cycle as req (cycle N) gives `instr_valid`=1 in cycle N+1.
- Commit in cycle M: `imem_req`=1 with the new `pc` in M+1.
- Minimum instruction period is 2 cycles with zero-wait memory.
- `rst` mid-fetch abandons the request; `imem_req` drops asynchronously.
- `pcsrc`, `imm_ext` and `alu_result` are sampled only in the EXEC cycle where `commit`=1.

## Structure
- Shared core package holds:
  - `pcsrc` encodings: `PCSRC_JALR`=2'b00, `PCSRC_TARGET`=2'b01, `PCSRC_PLUS4`=2'b10.
  - `NOP_INSTR` constant.
  - fetch FSM state encoding.
- One combinational sub-module, `next_pc_gen`: inputs `pc`, `pcsrc`, `imm_ext`, `alu_result`; outputs `next_pc` and `target_misaligned`.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning 32'h00500093 -> `imem_req` rises the cycle after IDLE; next cycle `instruction`=32'h00500093 and `instr_valid`=1.
- `pcsrc`=10 at `pc`=0x0000_0FFC, commit -> `pc`=0x0000_1000, `instret` +1.
- `pcsrc`=01, `imm_ext`=32'hFFFF_FFF8 at `pc`=0x20 -> `pc`=0x18. Separately, `pcsrc`=00, `alu_result`=0x45 -> `pc`=0x44.
- `pcsrc`=01, `imm_ext`=2 at `pc`=0x10 -> `misalign`=1, `pc` stays 0x10, `imem_req` stays 0 for 10 cycles, and `instr_valid`=0.
- 3-cycle wait states with `imem_rdata` toggling and `commit` pulsed during FETCH -> `imem_addr` stable, commit ignored, instruction captured only on ready.
- Assert `rst` mid-FETCH -> outputs return to reset values asynchronously; the fetch restarts at `RESET_PC`.
